byte_mask_memory: RTL

Parametrised dual-port synchronous RAM with per-byte write masks, selectable read-during-write behaviour, an optional output register and a post-reset clear sweep. It is the next-generation storage primitive for the core: it backs the data memory, where SB/SH/SW need byte-lane writes, and any table that must start zeroed. One write port and one read port share a single clock. Ready/valid-style status outputs let the load/store unit stall during clearing and track read latency.

---
 rtl/memory_pkg.sv | 30 +++
 rtl/memory_clear_sequencer.sv | 51 +++++
 rtl/byte_mask_memory.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/memory_pkg.sv
// Shared storage definitions: clear/ready state, byte width and the lane-merge
// helper used by both the RAM forwarding path and the load/store unit.
package memory_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  localparam int BYTE_WIDTH    = 8;
  localparam int MAX_WORD_SIZE = 256;
  localparam int MAX_LANES     = MAX_WORD_SIZE / BYTE_WIDTH;

  // Callers zero-extend narrower words into the maximum width and truncate the result.
  function automatic logic [MAX_WORD_SIZE-1:0] lane_merge(
    input logic [MAX_WORD_SIZE-1:0] old_word,
    input logic [MAX_WORD_SIZE-1:0] new_word,
    input logic [MAX_LANES-1:0]     mask
  );
    logic [MAX_WORD_SIZE-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (mask[i]) begin
        merged[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/memory_clear_sequencer.sv
// Post-reset clear FSM: sweeps every address once with zero writes, then
// holds READY until the next reset.
module memory_clear_sequencer
  import memory_pkg::*;
#(
  parameter int ADDRESS_SIZE   = 10,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    ready,
  output logic                    clear_enable,
  output logic [ADDRESS_SIZE-1:0] clear_address
);

  localparam logic [ADDRESS_SIZE-1:0] LAST_ADDRESS = '1;
  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  state_e                  state_q, state_d;
  logic [ADDRESS_SIZE-1:0] count_q, count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET_STATE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    clear_enable = 1'b0;
    if (state_q == CLEAR) begin
      clear_enable = 1'b1;
      // The last address is written on the same edge that enters READY; no wrap.
      if (count_q == LAST_ADDRESS) begin
        state_d = READY;
      end else begin
        count_d = count_q + ADDRESS_SIZE'(1);
      end
    end
  end

  assign ready         = (state_q == READY);
  assign clear_address = count_q;

endmodule

// File: rtl/byte_mask_memory.sv
// Dual-port byte-masked RAM with selectable read-during-write forwarding,
// optional output register and a post-reset zero sweep.
module byte_mask_memory
  import memory_pkg::*;
#(
  parameter int ADDRESS_SIZE    = 10,
  parameter int WORD_SIZE       = 32,
  parameter int OUTPUT_REGISTER = 0,
  parameter int WRITE_FIRST     = 1,
  parameter int CLEAR_ON_RESET  = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         read_enable,
  input  logic [ADDRESS_SIZE-1:0]      read_address,
  input  logic                         write_enable,
  input  logic [ADDRESS_SIZE-1:0]      write_address,
  input  logic [WORD_SIZE-1:0]         write_data,
  input  logic [WORD_SIZE/BYTE_WIDTH-1:0] write_mask,
  output logic [WORD_SIZE-1:0]         read_data,
  output logic                         read_valid,
  output logic                         ready
);

  localparam int LANES = WORD_SIZE / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDRESS_SIZE;

  if ((WORD_SIZE % BYTE_WIDTH) != 0 || WORD_SIZE > MAX_WORD_SIZE) begin : g_bad_word_size
    $error("byte_mask_memory: WORD_SIZE must be a multiple of 8 and at most MAX_WORD_SIZE");
  end

  logic                    clear_enable;
  logic [ADDRESS_SIZE-1:0] clear_address;

  memory_clear_sequencer #(
    .ADDRESS_SIZE  (ADDRESS_SIZE),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear_sequencer (
    .clk          (clk),
    .reset        (reset),
    .ready        (ready),
    .clear_enable (clear_enable),
    .clear_address(clear_address)
  );

  logic rd_fire, wr_fire;
  assign rd_fire = ready & read_enable;
  assign wr_fire = ready & write_enable;

  // Clear sweep owns the write port while it runs.
  logic                    mem_we;
  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0]    mem_data;
  logic [LANES-1:0]        mem_mask;

  always_comb begin
    mem_we   = wr_fire;
    mem_addr = write_address;
    mem_data = write_data;
    mem_mask = write_mask;
    if (clear_enable) begin
      mem_we   = 1'b1;
      mem_addr = clear_address;
      mem_data = '0;
      mem_mask = '1;
    end
  end

  logic [WORD_SIZE-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; it is zeroed by the clear sweep instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (mem_mask[i]) begin
          mem[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  logic [WORD_SIZE-1:0] rd_word_q, rd_word_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 fwd_match_q, fwd_match_d;
  logic [WORD_SIZE-1:0] fwd_data_q, fwd_data_d;
  logic [LANES-1:0]     fwd_mask_q, fwd_mask_d;

  // The array read returns the pre-write word; forwarding patches it afterwards.
  always_comb begin
    rd_word_d   = rd_word_q;
    rd_valid_d  = rd_fire;
    fwd_match_d = fwd_match_q;
    fwd_data_d  = fwd_data_q;
    fwd_mask_d  = fwd_mask_q;
    if (rd_fire) begin
      rd_word_d   = mem[read_address];
      fwd_match_d = (WRITE_FIRST != 0) && wr_fire && (read_address == write_address);
      fwd_data_d  = write_data;
      fwd_mask_d  = write_mask;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_word_q   <= '0;
      rd_valid_q  <= 1'b0;
      fwd_match_q <= 1'b0;
      fwd_data_q  <= '0;
      fwd_mask_q  <= '0;
    end else begin
      rd_word_q   <= rd_word_d;
      rd_valid_q  <= rd_valid_d;
      fwd_match_q <= fwd_match_d;
      fwd_data_q  <= fwd_data_d;
      fwd_mask_q  <= fwd_mask_d;
    end
  end

  logic [WORD_SIZE-1:0] merged_word;
  assign merged_word = fwd_match_q
    ? WORD_SIZE'(lane_merge(MAX_WORD_SIZE'(rd_word_q), MAX_WORD_SIZE'(fwd_data_q),
                            MAX_LANES'(fwd_mask_q)))
    : rd_word_q;

  if (OUTPUT_REGISTER != 0) begin : g_output_register
    logic [WORD_SIZE-1:0] out_data_q, out_data_d;
    logic                 out_valid_q;

    always_comb begin
      out_data_d = out_data_q;
      if (rd_valid_q) begin
        out_data_d = merged_word;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_data_q  <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_data_q  <= out_data_d;
        out_valid_q <= rd_valid_q;
      end
    end

    assign read_data  = out_data_q;
    assign read_valid = out_valid_q;
  end else begin : g_direct_output
    assign read_data  = merged_word;
    assign read_valid = rd_valid_q;
  end

endmodule
